// File: rtl/product_result_fifo.sv
// product_result_fifo
// Buffers 64-bit products from an upstream serial multiplier in a small
// first-word-fall-through FIFO and keeps a running sum and a saturating count
// of every product that was accepted.
//
// Ports:
//   CLK            sole clock, rising edge
//   RST_N          asynchronous active-low reset
//   Product        64-bit unsigned product
//   Product_Valid  one-cycle pulse qualifying Product
//   acc_clr        synchronous clear of acc_sum / prod_count
//   out_ready      downstream ready
//   out_data       head entry (0 while empty)
//   out_valid      out_data holds an entry
//   acc_sum        running sum of accepted products, modulo 2^ACC_W
//   prod_count     number of accepted products, saturating at 255
//   full / empty   occupancy flags
//   overflow       sticky: a product was dropped because the FIFO was full
module product_result_fifo #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 72
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [63:0]      Product,
    input  logic             Product_Valid,
    input  logic             acc_clr,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_sum,
    output logic [7:0]       prod_count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             ovf_q, ovf_d;

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [ACC_W-1:0] prod_ext_s;

    // Occupancy flags and handshake decode from registered state
    always_comb begin
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == {CNT_W{1'b0}});
        pop_s      = !empty_s && out_ready;
        // A pop on the same edge frees a slot, so a full FIFO can still accept
        push_s     = Product_Valid && (!full_s || pop_s);
        drop_s     = Product_Valid && full_s && !pop_s;
        prod_ext_s = ACC_W'(Product);
    end

    // Next-state for pointers, occupancy, accumulator, count and overflow
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        pcnt_d   = pcnt_q;
        ovf_d    = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear wins, but a product accepted on the clearing edge still counts
        if (acc_clr) begin
            if (push_s) begin
                acc_d  = prod_ext_s;
                pcnt_d = 8'd1;
            end else begin
                acc_d  = {ACC_W{1'b0}};
                pcnt_d = 8'd0;
            end
        end else if (push_s) begin
            acc_d = acc_q + prod_ext_s;
            if (pcnt_q != 8'd255) begin
                pcnt_d = pcnt_q + 8'd1;
            end else begin
                pcnt_d = pcnt_q;
            end
        end else begin
            acc_d  = acc_q;
            pcnt_d = pcnt_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and accumulator state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            pcnt_q   <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            pcnt_q   <= pcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; cleared on reset so no stale product survives it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= Product;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Output drive; out_data is forced to zero while nothing is held
    always_comb begin
        out_valid  = !empty_s;
        out_data   = empty_s ? 64'd0 : mem_q[rd_ptr_q];
        acc_sum    = acc_q;
        prod_count = pcnt_q;
        full       = full_s;
        empty      = empty_s;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_product_result_fifo.sv
module tb_product_result_fifo;

    localparam int DEPTH = 4;
    localparam int ACC_W = 72;

    logic             CLK;
    logic             RST_N;
    logic [63:0]      Product;
    logic             Product_Valid;
    logic             acc_clr;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_valid;
    logic [ACC_W-1:0] acc_sum;
    logic [7:0]       prod_count;
    logic             full;
    logic             empty;
    logic             overflow;

    product_result_fifo #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Product      (Product),
        .Product_Valid(Product_Valid),
        .acc_clr      (acc_clr),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .acc_sum      (acc_sum),
        .prod_count   (prod_count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: queue of stored products plus sum, count and sticky flag
    logic [63:0]      m_q[$];
    logic [ACC_W-1:0] m_acc;
    int               m_cnt;
    bit               m_ovf;

    int checks_r   = 0;
    int failures_r = 0;

    task automatic check_val(input string tag, input logic [ACC_W-1:0] obs,
                             input logic [ACC_W-1:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".valid"}, ACC_W'(out_valid), ACC_W'(m_q.size() != 0));
        check_val({tag, ".empty"}, ACC_W'(empty), ACC_W'(m_q.size() == 0));
        check_val({tag, ".full"},  ACC_W'(full),  ACC_W'(m_q.size() == DEPTH));
        if (m_q.size() != 0) begin
            check_val({tag, ".data"}, ACC_W'(out_data), ACC_W'(m_q[0]));
        end
        check_val({tag, ".acc"},   acc_sum, m_acc);
        check_val({tag, ".cnt"},   ACC_W'(prod_count), ACC_W'(m_cnt));
        check_val({tag, ".ovf"},   ACC_W'(overflow), ACC_W'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // One clock: drive at negedge, update model at the edge, compare after it
    task automatic step(input string tag, input bit pv, input logic [63:0] p,
                        input bit clr, input bit rdy);
        bit pop;
        bit acc;
        @(negedge CLK);
        Product       = p;
        Product_Valid = pv;
        acc_clr       = clr;
        out_ready     = rdy;
        pop = rdy && (m_q.size() != 0);
        acc = pv && ((m_q.size() < DEPTH) || pop);
        @(posedge CLK);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(p);
        if (clr) begin
            m_acc = acc ? ACC_W'(p) : '0;
            m_cnt = acc ? 1 : 0;
        end else if (acc) begin
            m_acc = m_acc + ACC_W'(p);
            if (m_cnt < 255) m_cnt++;
        end
        if (pv && !acc) m_ovf = 1'b1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        Product_Valid = 1'b0;
        acc_clr       = 1'b0;
        out_ready     = 1'b0;
        Product       = 64'd0;
        RST_N         = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        check_val({tag, ".rdata"}, ACC_W'(out_data), '0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N         = 1'b0;
        Product       = 64'd0;
        Product_Valid = 1'b0;
        acc_clr       = 1'b0;
        out_ready     = 1'b0;
        model_reset();
        #12;
        check_all("por");
        check_val("por.rdata", ACC_W'(out_data), '0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Single push with 1-cycle visibility
        step("single", 1'b1, 64'd42, 1'b0, 1'b0);
        check_val("single.data42", ACC_W'(out_data), ACC_W'(64'd42));
        check_val("single.acc42",  acc_sum, ACC_W'(42));
        check_val("single.cnt1",   ACC_W'(prod_count), ACC_W'(1));

        // Overflow: fifth product dropped, drain order preserved
        do_reset("rst1");
        for (int i = 1; i <= 5; i++) begin
            step("ovf.push", 1'b1, 64'(i), 1'b0, 1'b0);
            if (i == 4) check_val("ovf.full4", ACC_W'(full), ACC_W'(1));
        end
        check_val("ovf.flag", ACC_W'(overflow), ACC_W'(1));
        check_val("ovf.acc10", acc_sum, ACC_W'(10));
        check_val("ovf.cnt4", ACC_W'(prod_count), ACC_W'(4));
        for (int i = 1; i <= 4; i++) begin
            check_val("ovf.drain", ACC_W'(out_data), ACC_W'(i));
            step("ovf.pop", 1'b0, 64'd0, 1'b0, 1'b1);
        end
        check_val("ovf.empty", ACC_W'(empty), ACC_W'(1));

        // Simultaneous push and pop while full
        do_reset("rst2");
        for (int i = 1; i <= 4; i++) step("pp.fill", 1'b1, 64'(i), 1'b0, 1'b0);
        step("pp.both", 1'b1, 64'd9, 1'b0, 1'b1);
        check_val("pp.full",  ACC_W'(full), ACC_W'(1));
        check_val("pp.ovf0",  ACC_W'(overflow), ACC_W'(0));
        check_val("pp.acc19", acc_sum, ACC_W'(19));
        begin
            logic [63:0] exp_order [4];
            exp_order = '{64'd2, 64'd3, 64'd4, 64'd9};
            for (int i = 0; i < 4; i++) begin
                check_val("pp.order", ACC_W'(out_data), ACC_W'(exp_order[i]));
                step("pp.pop", 1'b0, 64'd0, 1'b0, 1'b1);
            end
        end

        // Clear with a coincident accept
        do_reset("rst3");
        step("clr.p100", 1'b1, 64'd100, 1'b0, 1'b0);
        check_val("clr.acc100", acc_sum, ACC_W'(100));
        step("clr.hit", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        check_val("clr.acc", acc_sum, 72'h00_FFFF_FFFF_FFFF_FFFF);
        check_val("clr.cnt1", ACC_W'(prod_count), ACC_W'(1));
        step("clr.only", 1'b0, 64'd0, 1'b1, 1'b0);

        // Mid-operation asynchronous reset
        do_reset("rst4");
        for (int i = 1; i <= 5; i++) step("mid.push", 1'b1, 64'(i + 10), 1'b0, 1'b0);
        step("mid.pop", 1'b0, 64'd0, 1'b0, 1'b1);
        check_val("mid.ovf1", ACC_W'(overflow), ACC_W'(1));
        @(negedge CLK);
        Product_Valid = 1'b0;
        out_ready     = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_val("mid.valid0", ACC_W'(out_valid), ACC_W'(0));
        check_val("mid.empty1", ACC_W'(empty), ACC_W'(1));
        check_val("mid.acc0",   acc_sum, ACC_W'(0));
        check_val("mid.cnt0",   ACC_W'(prod_count), ACC_W'(0));
        check_val("mid.ovf0",   ACC_W'(overflow), ACC_W'(0));
        #1;
        RST_N = 1'b1;
        step("mid.p7", 1'b1, 64'd7, 1'b0, 1'b0);
        check_val("mid.data7", ACC_W'(out_data), ACC_W'(7));

        // Random traffic with occasional clears
        do_reset("rst5");
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0));
        end
        // Long run without clears to reach count saturation
        for (int n = 0; n < 500; n++) begin
            step("sat", ($urandom_range(0, 7) != 0), {$urandom, $urandom},
                 1'b0, ($urandom_range(0, 7) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/product_result_fifo.md
PRODUCT_RESULT_FIFO -- requirements
Module: product_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of 64-bit product entries (power of two, >= 2).
REQ-002 SHALL have parameter ACC_W, default 72: accumulator width (>= 64).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port Product  input  64  unsigned product from the upstream serial multiplier.
REQ-006 SHALL have port Product_Valid  input  1  one-cycle pulse; Product is valid in that cycle.
REQ-007 SHALL have port acc_clr  input  1  synchronous clear of acc_sum and prod_count.
REQ-008 SHALL have port out_ready  input  1  downstream ready.
REQ-009 SHALL have port out_data  output  64  head FIFO entry.
REQ-010 SHALL have port out_valid  output  1  out_data holds an entry.
REQ-011 SHALL have port acc_sum  output  ACC_W  running sum of accepted products.
REQ-012 SHALL have port prod_count  output  8  number of accepted products, saturating.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-015 SHALL have port overflow  output  1  sticky flag: a product was dropped.

Function
REQ-016 SHALL store entries in registered storage with read/write pointers and an occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-017 SHALL drive out_valid = !empty, and out_data = head entry, first-word-fall-through; out_data is don't-care while empty.
REQ-018 SHALL pop on an edge where out_valid && out_ready, advancing the read pointer.
REQ-019 SHALL accept (push) Product on an edge where Product_Valid && (!full || pop).
REQ-020 SHALL make an accepted entry visible on out_data/out_valid in the cycle after the accepting edge (1-cycle latency).
REQ-021 SHALL keep occupancy unchanged on a simultaneous push and pop, including when full.
REQ-022 SHALL not pop when empty; a push into an empty FIFO with out_ready=1 is a push only.
REQ-023 SHALL drop Product when Product_Valid && full && !pop: storage, pointers, acc_sum and prod_count unchanged; overflow set to 1.
REQ-024 SHALL keep overflow at 1 until RST_N asserts; acc_clr does not clear it.
REQ-025 SHALL add each accepted Product, zero-extended, to acc_sum, modulo 2^ACC_W.
REQ-026 SHALL increment prod_count on each accept, saturating at 255.
REQ-027 SHALL give acc_clr priority, then apply a coincident accept: acc_sum <= Product, prod_count <= 1; without an accept, both <= 0.
REQ-028 SHALL derive full = (count == DEPTH) and empty = (count == 0) from registered occupancy.

Reset
REQ-029 SHALL, while RST_N = 0 and independent of CLK, force pointers and occupancy to 0, acc_sum = 0, prod_count = 0 and overflow = 0; outputs read out_valid = 0, empty = 1, full = 0, out_data = 0.
REQ-030 SHALL discard all stored entries on reset, including a reset asserted mid-operation; the first edge after RST_N deasserts is a normal operating edge.

Verification
REQ-031 SHALL verify single push: after reset, Product = 64'd42 pulsed with out_ready = 0 -> next cycle out_valid = 1, out_data = 42, acc_sum = 42, prod_count = 1, empty = 0.
REQ-032 SHALL verify overflow: push 1, 2, 3, 4, 5 with out_ready = 0 -> full = 1 after the 4th; 5 dropped; overflow = 1; acc_sum = 10; prod_count = 4; draining yields 1, 2, 3, 4, then empty = 1.
REQ-033 SHALL verify simultaneous push/pop at full: FIFO holds 1..4, push 9 with out_ready = 1 -> 1 popped, occupancy stays 4, order 2, 3, 4, 9; overflow stays 0; acc_sum = 19.
REQ-034 SHALL verify clear with coincident accept: acc_sum = 100, acc_clr = 1 with Product = 64'hFFFF_FFFF_FFFF_FFFF -> acc_sum = 72'h00_FFFF_FFFF_FFFF_FFFF, prod_count = 1.
REQ-035 SHALL verify mid-operation reset: 3 entries held, overflow = 1, RST_N pulsed low between edges -> immediately out_valid = 0, empty = 1, acc_sum = 0, prod_count = 0, overflow = 0; the next push of 7 appears as out_data = 7.
